// File: rtl/fp_norm_pack.sv
// FP adder final stage: leading-one normalise, exponent adjust, zero/denormal/special packing.
// Two registered stages (2 enabled cycles); EN=0 freezes both stages, valid bits included.
module fp_norm_pack #(
  parameter int MW  = 24,
  parameter int EW  = 8,
  parameter int LZW = 5
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic          IN_VALID,
  input  logic          AS1,
  input  logic          BS1,
  input  logic          E1,
  input  logic [MW-1:0] Z1,
  input  logic [EW-1:0] ZE1,
  input  logic          ZS1,
  output logic          OUT_VALID,
  output logic [31:0]   RESULT,
  output logic          UNDERFLOW
);

  logic [LZW-1:0] lz_c;

  logic           s1_vld;
  logic           s1_as;
  logic           s1_bs;
  logic           s1_e;
  logic [MW-1:0]  s1_z;
  logic [EW-1:0]  s1_ze;
  logic           s1_zs;
  logic [LZW-1:0] s1_lz;
  logic           s1_zf;

  logic           lt_c;
  logic [EW-1:0]  lz_ext_c;
  logic [EW-1:0]  sh_c;
  logic [EW-1:0]  amt_c;
  logic [MW-1:0]  zsh_c;
  logic [EW-1:0]  exp_c;
  logic [31:0]    res_c;
  logic           uf_c;

  // Ascending scan: the last hit is the highest set bit. Z1==0 yields MW-1.
  always_comb begin
    lz_c = LZW'(MW - 1);
    for (int i = 0; i < MW; i++) begin
      if (Z1[i]) lz_c = LZW'(MW - 1 - i);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_vld <= 1'b0;
      s1_as  <= 1'b0;
      s1_bs  <= 1'b0;
      s1_e   <= 1'b0;
      s1_z   <= '0;
      s1_ze  <= '0;
      s1_zs  <= 1'b0;
      s1_lz  <= '0;
      s1_zf  <= 1'b0;
    end else if (EN) begin
      s1_vld <= IN_VALID;
      s1_as  <= AS1;
      s1_bs  <= BS1;
      s1_e   <= E1;
      s1_z   <= Z1;
      s1_ze  <= ZE1;
      s1_zs  <= ZS1;
      s1_lz  <= lz_c;
      s1_zf  <= (Z1 == '0);
    end
  end

  assign lz_ext_c = {{(EW-LZW){1'b0}}, s1_lz};
  assign lt_c     = lz_ext_c < s1_ze;
  assign sh_c     = (s1_ze == '0) ? '0 : s1_ze - EW'(1);
  // Denormal shift stops at exponent 1's position; it never exceeds lz, so no set bit is lost.
  assign amt_c    = lt_c ? lz_ext_c : sh_c;
  assign zsh_c    = s1_z << amt_c;
  assign exp_c    = s1_ze - lz_ext_c;

  always_comb begin
    res_c = '0;
    uf_c  = 1'b0;
    if (s1_e) begin
      res_c = {s1_zs, {EW{1'b1}}, s1_z[MW-2:0]};
    end else if (s1_zf) begin
      res_c = {((s1_as == s1_bs) ? s1_as : 1'b0), 31'b0};
    end else if (lt_c) begin
      res_c = {s1_zs, exp_c, zsh_c[MW-2:0]};
    end else begin
      res_c = {s1_zs, {EW{1'b0}}, zsh_c[MW-2:0]};
      uf_c  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      RESULT    <= '0;
      UNDERFLOW <= 1'b0;
    end else if (EN) begin
      OUT_VALID <= s1_vld;
      RESULT    <= res_c;
      UNDERFLOW <= uf_c;
    end
  end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Self-checking bench for fp_norm_pack: directed vectors, stall, reset flush and random stream
// against a numeric reference model plus an enabled-edge delay queue.
module tb_fp_norm_pack;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic        IN_VALID;
  logic        AS1;
  logic        BS1;
  logic        E1;
  logic [23:0] Z1;
  logic [7:0]  ZE1;
  logic        ZS1;
  logic        OUT_VALID;
  logic [31:0] RESULT;
  logic        UNDERFLOW;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic        as_;
    logic        bs_;
    logic        e_;
    logic [23:0] z;
    logic [7:0]  ze;
    logic        zs;
  } item_t;

  typedef struct {
    logic        v;
    logic        uf;
    logic [31:0] res;
  } exp_t;

  typedef struct {
    item_t       it;
    logic        uf;
    logic [31:0] res;
  } vec_t;

  exp_t q[$];

  fp_norm_pack dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN        (EN),
    .IN_VALID  (IN_VALID),
    .AS1       (AS1),
    .BS1       (BS1),
    .E1        (E1),
    .Z1        (Z1),
    .ZE1       (ZE1),
    .ZS1       (ZS1),
    .OUT_VALID (OUT_VALID),
    .RESULT    (RESULT),
    .UNDERFLOW (UNDERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: normalise by repeated doubling until the hidden bit is set.
  function automatic logic [32:0] ref_pack(input item_t it);
    longint m;
    int     lz;
    int     sh;
    logic [22:0] f;
    if (it.e_) return {1'b0, it.zs, 8'hFF, it.z[22:0]};
    if (it.z == 24'h0) return {1'b0, ((it.as_ == it.bs_) ? it.as_ : 1'b0), 31'b0};
    m  = longint'(it.z);
    lz = 0;
    while (m < 64'd8388608) begin
      m  = m * 2;
      lz = lz + 1;
    end
    if (lz < int'(it.ze)) begin
      f = 23'(m % 64'd8388608);
      return {1'b0, it.zs, 8'(int'(it.ze) - lz), f};
    end
    sh = (it.ze == 8'd0) ? 0 : int'(it.ze) - 1;
    m  = longint'(it.z) * (longint'(1) << sh);
    f  = 23'(m % 64'd8388608);
    return {1'b1, it.zs, 8'h00, f};
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.as_ = 1'($urandom);
    it.bs_ = 1'($urandom);
    it.e_  = ($urandom_range(0, 7) == 0);
    it.z   = 24'($urandom) >> $urandom_range(0, 24);
    it.ze  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 25)) : 8'($urandom);
    it.zs  = 1'($urandom);
    return it;
  endfunction

  task automatic drive(input logic v, input item_t it);
    IN_VALID = v;
    AS1 = it.as_;
    BS1 = it.bs_;
    E1  = it.e_;
    Z1  = it.z;
    ZE1 = it.ze;
    ZS1 = it.zs;
  endtask

  // Advance one clock and update the delay-queue model: q[0] is the expected output.
  task automatic tick();
    exp_t        n;
    exp_t        z0;
    logic [32:0] r;
    item_t       it;
    z0.v = 1'b0; z0.uf = 1'b0; z0.res = 32'h0;
    @(posedge CLK);
    if (!RST_N) begin
      q.delete();
      q.push_back(z0);
      q.push_back(z0);
    end else if (EN) begin
      it    = '{AS1, BS1, E1, Z1, ZE1, ZS1};
      r     = ref_pack(it);
      n.v   = IN_VALID;
      n.uf  = r[32];
      n.res = r[31:0];
      q.push_back(n);
      void'(q.pop_front());
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    EN    = 1'b0;
    drive(1'b1, rand_item());
    tick();
    tick();
    total_cnt++;
    if (OUT_VALID !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID);
    else pass_cnt++;
    total_cnt++;
    if (RESULT !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", RESULT);
    else pass_cnt++;
    total_cnt++;
    if (UNDERFLOW !== 1'b0) $display("FAIL reset_underflow: got %b expected 0", UNDERFLOW);
    else pass_cnt++;
    RST_N = 1'b1;
    EN    = 1'b1;
    drive(1'b0, '0);
    tick();
    tick();
  endtask

  task automatic test_directed();
    vec_t tv[9] = '{
      '{'{1'b0, 1'b0, 1'b0, 24'h800000, 8'd127, 1'b0}, 1'b0, 32'h3F800000},
      '{'{1'b1, 1'b1, 1'b0, 24'h000001, 8'd150, 1'b1}, 1'b0, 32'hBF800000},
      '{'{1'b1, 1'b0, 1'b0, 24'h000000, 8'd50,  1'b1}, 1'b0, 32'h00000000},
      '{'{1'b1, 1'b1, 1'b0, 24'h000000, 8'd50,  1'b1}, 1'b0, 32'h80000000},
      '{'{1'b0, 1'b0, 1'b0, 24'h100000, 8'd2,   1'b0}, 1'b1, 32'h00200000},
      '{'{1'b0, 1'b0, 1'b0, 24'h400000, 8'd0,   1'b0}, 1'b1, 32'h00400000},
      '{'{1'b0, 1'b0, 1'b1, 24'h400000, 8'd0,   1'b0}, 1'b0, 32'h7FC00000},
      '{'{1'b0, 1'b0, 1'b0, 24'h100000, 8'd4,   1'b0}, 1'b0, 32'h00800000},
      '{'{1'b0, 1'b0, 1'b0, 24'h100000, 8'd3,   1'b1}, 1'b1, 32'h80400000}
    };
    EN = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      if (c < 9) drive(1'b1, tv[c].it);
      else drive(1'b0, '0);
      tick();
      if (c >= 1) begin
        total_cnt++;
        if ({OUT_VALID, UNDERFLOW, RESULT} !== {1'b1, tv[c-1].uf, tv[c-1].res})
          $display("FAIL directed_%0d: got v=%b uf=%b res=%h expected v=1 uf=%b res=%h",
                   c - 1, OUT_VALID, UNDERFLOW, RESULT, tv[c-1].uf, tv[c-1].res);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_stall();
    logic        en_s[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    item_t       items[4];
    logic [31:0] expq[$];
    logic [31:0] gotq[$];
    logic [32:0] r;
    logic [31:0] got;
    int          k = 0;
    EN = 1'b1;
    drive(1'b0, '0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      items[i] = rand_item();
      r = ref_pack(items[i]);
      expq.push_back(r[31:0]);
    end
    for (int i = 0; i < 11; i++) begin
      EN = en_s[i];
      if (k < 4) drive(1'b1, items[k]);
      else drive(1'b0, '0);
      tick();
      total_cnt++;
      if ({OUT_VALID, UNDERFLOW, RESULT} !== {q[0].v, q[0].uf, q[0].res})
        $display("FAIL stall_cycle_%0d: got v=%b uf=%b res=%h expected v=%b uf=%b res=%h",
                 i, OUT_VALID, UNDERFLOW, RESULT, q[0].v, q[0].uf, q[0].res);
      else pass_cnt++;
      if (EN && k < 4) k++;
      if (EN && OUT_VALID) gotq.push_back(RESULT);
    end
    total_cnt++;
    if (gotq.size() != 4) $display("FAIL stall_count: got %0d outputs expected 4", gotq.size());
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      got = (i < gotq.size()) ? gotq[i] : 32'hxxxxxxxx;
      total_cnt++;
      if (got !== expq[i]) $display("FAIL stall_order_%0d: got %h expected %h", i, got, expq[i]);
      else pass_cnt++;
    end
    EN = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      EN = ($urandom_range(0, 3) != 0);
      drive(1'($urandom), rand_item());
      tick();
      total_cnt++;
      if ({OUT_VALID, UNDERFLOW, RESULT} !== {q[0].v, q[0].uf, q[0].res})
        $display("FAIL random_%0d: got v=%b uf=%b res=%h expected v=%b uf=%b res=%h",
                 i, OUT_VALID, UNDERFLOW, RESULT, q[0].v, q[0].uf, q[0].res);
      else pass_cnt++;
    end
    EN = 1'b1;
  endtask

  task automatic test_reset_flush();
    item_t it;
    EN = 1'b1;
    it = '{1'b0, 1'b0, 1'b0, 24'h800000, 8'd127, 1'b0};
    drive(1'b1, it);
    tick();
    it = '{1'b0, 1'b0, 1'b0, 24'hC00000, 8'd130, 1'b1};
    drive(1'b1, it);
    tick();
    total_cnt++;
    if ({OUT_VALID, RESULT} !== {1'b1, 32'h3F800000})
      $display("FAIL flush_pre: got v=%b res=%h expected v=1 res=3f800000", OUT_VALID, RESULT);
    else pass_cnt++;
    RST_N = 1'b0;
    drive(1'b1, it);
    tick();
    total_cnt++;
    if ({OUT_VALID, UNDERFLOW, RESULT} !== 34'h0)
      $display("FAIL flush_reset: got v=%b uf=%b res=%h expected all 0", OUT_VALID, UNDERFLOW, RESULT);
    else pass_cnt++;
    RST_N = 1'b1;
    drive(1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if (OUT_VALID !== 1'b0)
        $display("FAIL flush_drop_%0d: got out_valid=%b expected 0", i, OUT_VALID);
      else pass_cnt++;
    end
  endtask

  initial begin
    RST_N = 1'b0;
    EN    = 1'b0;
    drive(1'b0, '0);
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
